// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud timing and frame shape.
// The state encoding is common to the transmitter and the receiver.
package uart_pkg;

    localparam int CLK_FREQ     = 100_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        CLEAN_UP = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for one asynchronous input.
// RST_VAL is the value both flops take in reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Validates the start bit at mid-bit, samples each
// data bit at its centre and emits one-cycle valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT  // must be >= 4 and even
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int H = CLKS_PER_BIT / 2;
    localparam logic [15:0] CNT_HALF = 16'(H - 1);
    localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_t          state, state_nx;
    logic [15:0]          clk_cnt, clk_cnt_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic [DATA_BITS-1:0] data_nx;
    logic                 valid_nx, frame_err_nx;
    logic                 armed, armed_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b1;
        end else begin
            state     <= state_nx;
            clk_cnt   <= clk_cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            data_out  <= data_nx;
            valid     <= valid_nx;
            frame_err <= frame_err_nx;
            armed     <= armed_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        clk_cnt_nx   = clk_cnt + 16'd1;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        data_nx      = data_out;
        valid_nx     = 1'b0;
        frame_err_nx = 1'b0;
        armed_nx     = armed;

        case (state)
            IDLE: begin
                clk_cnt_nx = '0;
                bit_idx_nx = '0;
                if (rx_s)
                    armed_nx = 1'b1;
                if (armed && !rx_s)
                    state_nx = START;
            end
            START: begin
                // Low still present at mid start bit: a real frame, else a glitch.
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nx = '0;
                    state_nx   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_nx = '0;
                    shreg_nx   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT)
                        state_nx = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_nx = '0;
                    state_nx   = CLEAN_UP;
                    if (rx_s) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                    end else begin
                        // Disarm so a held-low break cannot start a new frame.
                        frame_err_nx = 1'b1;
                        armed_nx     = 1'b0;
                    end
                end
            end
            CLEAN_UP: begin
                clk_cnt_nx = '0;
                state_nx   = IDLE;
            end
            default: begin
                clk_cnt_nx = '0;
                state_nx   = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
